unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter that shares one single-port synchronous memory of NUM_MEM_LOCS words between the instruction-fetch (IF) port and the data (MEM-stage) port of the pipelined RISC-V processor. Each cycle it grants at most one requester. Data accesses have priority; a starvation counter guarantees forward progress for fetch. It also returns read data one cycle after the grant, and exposes a conflict counter for performance debug.

## Interface
Parameters:
- REG_WIDTH, 32, data word width
- NUM_MEM_LOCS, 256, memory depth in words; ADDR_W = $clog2(NUM_MEM_LOCS)
- STARVE_LIMIT, 4, consecutive denied IF-request cycles after which IF wins a conflict (legal range 1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_ready  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  REG_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  REG_WIDTH  write data
- d_ready  out  1  data request granted this cycle (combinational)
- d_rvalid  out  1  data read data valid
- d_rdata  out  REG_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  REG_WIDTH  memory write data
- mem_rdata  in  REG_WIDTH  memory read data, valid the cycle after mem_en & !mem_we
- conflict_cnt  out  16  cycles with if_req & d_req, saturating

## Operation
- Grant rule, evaluated every cycle:
  - If only one port requests, that port is granted.
  - If both request, D is granted unless starve_cnt == STARVE_LIMIT, in which case IF is granted.
  - If neither requests, there is no grant and mem_en = 0.
- Memory drive:
  - mem_en = if_ready | d_ready.
  - mem_we = d_ready & d_we.
  - mem_addr and mem_wdata come from the granted port.
  - When there is no grant, mem_addr and mem_wdata are 0.
- starve_cnt (4-bit register):
  - Cleared when IF is granted or when if_req = 0.
  - Incremented when if_req = 1 and IF is not granted.
  - Saturates at STARVE_LIMIT.
- resp_owner register, values NONE / IF / D:
  - Next value is IF on an IF grant, D on a D-read grant, NONE otherwise. A D write sets NONE.
  - if_rvalid = (resp_owner == IF); d_rvalid = (resp_owner == D).
  - Each rdata output equals mem_rdata when its rvalid is 1, otherwise 0.
- Writes complete in the grant cycle and produce no rvalid.
- conflict_cnt increments in every cycle with if_req & d_req, and saturates at 16'hFFFF.
- Requesters hold req and address stable until ready. The pipeline uses req & !ready as its stall.

## Timing
- Grant latency is 0 cycles: ready is combinational from req and the registered starve_cnt.
- Read latency is 1 cycle: a read granted in cycle N has rvalid high in cycle N+1.
- Back-to-back grants to either port are allowed. Sustained throughput is one access per cycle.
- Worst-case IF wait under continuous D traffic is STARVE_LIMIT cycles; IF is granted in the (STARVE_LIMIT+1)th cycle of requesting.
- Reset values, set at the clock edge where rst = 1:
  - starve_cnt = 0, resp_owner = NONE, conflict_cnt = 0.
  - if_rvalid = d_rvalid = 0 in the following cycle.
- Reset mid-operation: a read granted in the cycle rst is asserted is discarded (no rvalid).
- While rst = 1, if_ready, d_ready and mem_en are forced to 0.
- Simultaneous IF grant and counter saturation: the counter clears in the same edge.

## Test plan
- Reset, then IF-only reads of addresses 0..3 with memory preloaded with i*4 -> if_ready = 1 each cycle; if_rvalid one cycle later with if_rdata 0, 4, 8, 12; d_rvalid stays 0.
- D write 0xDEADBEEF to address 10, then D read of address 10 -> mem_we = 1 in cycle 1 and no rvalid; d_rvalid in cycle 3 with d_rdata = 0xDEADBEEF.
- Continuous if_req and d_req (reads) for 12 cycles, STARVE_LIMIT = 4 -> grant pattern D,D,D,D,IF repeating (IF in cycles 5 and 10); conflict_cnt = 12 afterwards.
- Simultaneous D write and IF read of the same address -> D is granted (write happens); IF is granted the next cycle and reads the new value.
- Assert rst in the cycle a D read is granted -> no d_rvalid the next cycle; all counters 0; ready outputs low while rst = 1.
- Force 65540 conflict cycles -> conflict_cnt holds at 0xFFFF with no wrap.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// port (IF) and the data port (D) of the pipelined processor. At most one
// requester is granted per cycle. D normally wins a conflict. A starvation
// counter lets IF win once it has been denied STARVE_LIMIT cycles in a row.
// Read data returns one cycle after the grant and is steered to the port
// that owned the access.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   if_req/if_addr        fetch read request and word address
//   if_ready              fetch granted this cycle (combinational)
//   if_rvalid/if_rdata    fetch read response, one cycle after grant
//   d_req/d_we/d_addr     data request, write flag and word address
//   d_wdata               data write value
//   d_ready               data granted this cycle (combinational)
//   d_rvalid/d_rdata      data read response, one cycle after grant
//   mem_en/mem_we         memory access strobe and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata             memory read data (one cycle after a read)
//   conflict_cnt          saturating count of cycles with both requests
module unified_mem_arbiter #(
  parameter int REG_WIDTH    = 32,
  parameter int NUM_MEM_LOCS = 256,
  parameter int STARVE_LIMIT = 4,
  localparam int ADDR_W      = $clog2(NUM_MEM_LOCS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_ready,
  output logic                 if_rvalid,
  output logic [REG_WIDTH-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [REG_WIDTH-1:0] d_wdata,
  output logic                 d_ready,
  output logic                 d_rvalid,
  output logic [REG_WIDTH-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic [REG_WIDTH-1:0] mem_rdata,
  output logic [15:0]          conflict_cnt
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [1:0] resp_owner;
  logic       starved;

  assign starved = (starve_cnt == STARVE_MAX);

  // IF wins when it is alone or has been starved long enough; D takes
  // whatever IF does not. Both are held off while reset is asserted.
  assign if_ready = !rst && if_req && (!d_req || starved);
  assign d_ready  = !rst && d_req && !if_ready;

  // Memory port follows the granted requester; idle cycles drive zeros
  // so the bus is quiet and deterministic.
  always_comb begin
    mem_en    = if_ready | d_ready;
    mem_we    = d_ready & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_ready) begin
      mem_addr = if_addr;
    end else if (d_ready) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Counts consecutive denied IF cycles; any IF grant or a dropped IF
  // request restarts the count, which holds at the limit until IF wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_ready) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remembers who issued the read this cycle so next cycle's memory data
  // is handed to the right port. Writes and idle cycles leave no owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner <= OWN_NONE;
    end else if (if_ready) begin
      resp_owner <= OWN_IF;
    end else if (d_ready && !d_we) begin
      resp_owner <= OWN_D;
    end else begin
      resp_owner <= OWN_NONE;
    end
  end

  // Performance-debug count of contended cycles; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (if_req && d_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign d_rvalid  = (resp_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed stimulus, with expected read
// responses queued at issue time and retired by an independent monitor.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem_model [0:255];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(
    .REG_WIDTH(32),
    .NUM_MEM_LOCS(256),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ready(if_ready),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous memory, preloaded with word i = i*4.
  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'(i * 4);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [7:0] ifa, input logic dr,
                               input logic dwe, input logic [7:0] da, input logic [31:0] dwd);
    if_req  = ifr;
    if_addr = ifa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retires queued expectations whenever a response is presented,
  // and insists that idle response buses read as zero.
  always @(negedge clk) begin
    if (if_rvalid === 1'b1) begin
      if (if_q.size() == 0) checkOutput("if_unexpected_rvalid", 32'd1, 32'd0);
      else checkOutput("if_rdata", if_rdata, if_q.pop_front());
    end else if (if_rdata !== 32'd0) begin
      checkOutput("if_rdata_idle", if_rdata, 32'd0);
    end
    if (d_rvalid === 1'b1) begin
      if (d_q.size() == 0) checkOutput("d_unexpected_rvalid", 32'd1, 32'd0);
      else checkOutput("d_rdata", d_rdata, d_q.pop_front());
    end else if (d_rdata !== 32'd0) begin
      checkOutput("d_rdata_idle", d_rdata, 32'd0);
    end
  end

  // Watchdog so the bench always reaches its summary.
  initial begin
    #2000000;
    checkOutput("watchdog_timeout", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic expIf;
    rst = 1'b1;
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b0, 8'd2, 32'd0);

    // Reset holds grants and memory strobe low even with both requesting.
    tick();
    @(negedge clk);
    checkOutput("rst_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("rst_d_ready", {31'd0, d_ready}, 32'd0);
    checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    checkOutput("reset_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    checkOutput("reset_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    checkOutput("reset_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("idle_mem_en", {31'd0, mem_en}, 32'd0);
    tick();

    // IF-only reads of addresses 0..3 return 0, 4, 8, 12.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 8'd0, 32'd0);
      if_q.push_back(32'(i * 4));
      @(negedge clk);
      checkOutput("ifonly_if_ready", {31'd0, if_ready}, 32'd1);
      checkOutput("ifonly_mem_addr", {24'd0, mem_addr}, 32'(i));
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    tick();

    // D write of DEADBEEF to address 10, then read it back.
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd10, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("dwr_d_ready", {31'd0, d_ready}, 32'd1);
    checkOutput("dwr_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("dwr_mem_addr", {24'd0, mem_addr}, 32'd10);
    checkOutput("dwr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd10, 32'd0);
    d_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checkOutput("drd_d_ready", {31'd0, d_ready}, 32'd1);
    checkOutput("drd_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("drd_mem_wdata", mem_wdata, 32'd0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    tick();

    // Twelve contended read cycles: D,D,D,D,IF repeating.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'd0);
      expIf = (k % 5 == 0);
      if (expIf) if_q.push_back(32'd80);
      else       d_q.push_back(32'd120);
      @(negedge clk);
      checkOutput($sformatf("conflict%0d_if_ready", k), {31'd0, if_ready}, {31'd0, expIf});
      checkOutput($sformatf("conflict%0d_d_ready", k), {31'd0, d_ready}, {31'd0, !expIf});
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    checkOutput("conflict_cnt_12", {16'd0, conflict_cnt}, 32'd12);
    tick();

    // Same-address D write and IF read: write first, IF sees the new value.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 32'h12345678);
    @(negedge clk);
    checkOutput("raw_d_ready", {31'd0, d_ready}, 32'd1);
    checkOutput("raw_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("raw_mem_we", {31'd0, mem_we}, 32'd1);
    tick();
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 32'd0);
    if_q.push_back(32'h12345678);
    @(negedge clk);
    checkOutput("raw_if_ready_next", {31'd0, if_ready}, 32'd1);
    tick();

    // Build up starvation, then reset in the cycle a D read would win.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'd0);
      d_q.push_back(32'd120);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_d_ready", {31'd0, d_ready}, 32'd0);
    checkOutput("midrst_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    checkOutput("midrst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("midrst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    tick();

    // Starvation count restarted from zero: IF wins on the fifth cycle.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'd0);
      expIf = (k == 5);
      if (expIf) if_q.push_back(32'd80);
      else       d_q.push_back(32'd120);
      @(negedge clk);
      checkOutput($sformatf("postrst%0d_if_ready", k), {31'd0, if_ready}, {31'd0, expIf});
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    checkOutput("postrst_conflict_cnt", {16'd0, conflict_cnt}, 32'd5);
    tick();

    // 65540 contended cycles (D writes, IF reads of address 0) saturate the
    // conflict counter at 0xFFFF.
    for (int k = 1; k <= 65540; k++) begin
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b1, 8'd200, 32'd0);
      if (k % 5 == 0) if_q.push_back(32'd0);
      if (k == 65531) begin
        @(negedge clk);
        checkOutput("sat_reach_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
      end
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    checkOutput("sat_hold_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
    tick();
    tick();

    @(negedge clk);
    checkOutput("if_queue_drained", 32'(if_q.size()), 32'd0);
    checkOutput("d_queue_drained", 32'(d_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
